// File: rtl/riscv_irq_pend_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_irq_pend_ctrl
//
// Purpose:
//    Latches the synchronized single-cycle interrupt pulses (timer, gpio, debug)
//    into per-source pending bits. It applies the CSR enables, picks one source
//    by fixed priority (timer > gpio > debug), and holds a stable request/ID
//    handshake toward the core. It also flags lost events (a pulse on a source
//    that is already pending) and acknowledges that do not match the ID on offer.
//
// Ports:
//    clk                core clock
//    rst_n              asynchronous active-low reset
//    irq_*_pulse_i      synchronized rising-edge pulses (timer, gpio, debug)
//    irq_en_i[2:0]      per-source enable {debug,gpio,timer}
//    mie_i              global enable; gates timer and gpio, not debug
//    debug_mode_i       core is in debug mode; blocks every source
//    irq_req_o          interrupt request to the core
//    irq_id_o           ID on offer; holds its last value when irq_req_o=0
//    irq_ack_i          single-cycle acknowledge from the core
//    irq_id_i           ID being acknowledged
//    pending_o[2:0]     pending bits {debug,gpio,timer}
//    lost_o[2:0]        sticky lost-event flags {debug,gpio,timer}
//    lost_cnt_o         saturating lost-event counter
//    lost_clr_i         clears lost_o and lost_cnt_o; wins over a same-cycle event
//    ack_err_o          one-cycle pulse after an ack with a bad ID or no request
// -----------------------------------------------------------------------------
module riscv_irq_pend_ctrl #(
   parameter logic [4:0] ID_TIMER   = 5'd7,
   parameter logic [4:0] ID_GPIO    = 5'd11,
   parameter logic [4:0] ID_DEBUG   = 5'd12,
   parameter int         LOST_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  irq_timer_pulse_i,
   input  logic                  irq_gpio_pulse_i,
   input  logic                  irq_debug_pulse_i,
   input  logic [2:0]            irq_en_i,
   input  logic                  mie_i,
   input  logic                  debug_mode_i,
   output logic                  irq_req_o,
   output logic [4:0]            irq_id_o,
   input  logic                  irq_ack_i,
   input  logic [4:0]            irq_id_i,
   output logic [2:0]            pending_o,
   output logic [2:0]            lost_o,
   output logic [LOST_CNT_W-1:0] lost_cnt_o,
   input  logic                  lost_clr_i,
   output logic                  ack_err_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      REQ   = 2'b01,
      DRAIN = 2'b10
   } state_t;

   // Number of sources that lost an event this cycle (0..3).
   function automatic logic [1:0] popcount3(input logic [2:0] v);
      popcount3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

   state_t                state_r;
   state_t                state_nxt_s;
   logic [2:0]            pending_r;
   logic [2:0]            lost_r;
   logic [2:0]            sel_r;          // one-hot source currently on offer
   logic                  irq_req_r;
   logic [4:0]            irq_id_r;
   logic                  ack_err_r;
   logic [LOST_CNT_W-1:0] lost_cnt_r;

   logic [2:0]            pulse_s;
   logic [2:0]            elig_s;
   logic                  held_elig_s;
   logic                  ack_ok_s;
   logic [2:0]            clr_s;
   logic [2:0]            lost_ev_s;
   logic [1:0]            lost_num_s;
   logic [LOST_CNT_W+1:0] cnt_sum_s;
   logic [LOST_CNT_W+1:0] cnt_max_s;
   logic [LOST_CNT_W-1:0] lost_cnt_nxt_s;
   logic [2:0]            pending_nxt_s;
   logic [2:0]            lost_nxt_s;
   logic                  req_nxt_s;
   logic [4:0]            id_nxt_s;
   logic [2:0]            sel_nxt_s;
   logic                  ack_err_nxt_s;

   assign pulse_s = {irq_debug_pulse_i, irq_gpio_pulse_i, irq_timer_pulse_i};

   // Debug ignores mie_i, but debug mode blocks every source.
   assign elig_s[0] = pending_r[0] & irq_en_i[0] & mie_i & ~debug_mode_i;
   assign elig_s[1] = pending_r[1] & irq_en_i[1] & mie_i & ~debug_mode_i;
   assign elig_s[2] = pending_r[2] & irq_en_i[2] & ~debug_mode_i;

   assign held_elig_s = |(elig_s & sel_r);

   // An ack is only valid while a request is on offer and the ID matches it.
   assign ack_ok_s      = irq_ack_i & (state_r == REQ) & (irq_id_i == irq_id_r);
   assign ack_err_nxt_s = irq_ack_i & ~ack_ok_s;
   assign clr_s         = ack_ok_s ? sel_r : 3'b000;

   // A pulse in the same cycle as the clearing ack re-arms the bit. It does not
   // count as lost because the earlier event was consumed by that ack.
   assign lost_ev_s  = pulse_s & pending_r & ~clr_s;
   assign lost_num_s = popcount3(lost_ev_s);
   assign cnt_sum_s  = {2'b00, lost_cnt_r} + {{LOST_CNT_W{1'b0}}, lost_num_s};
   assign cnt_max_s  = {2'b00, {LOST_CNT_W{1'b1}}};

   // Next pending bits, lost flags and saturating lost counter.
   always_comb begin
      pending_nxt_s  = (pending_r & ~clr_s) | pulse_s;
      lost_nxt_s     = lost_r;
      lost_cnt_nxt_s = lost_cnt_r;
      if (lost_clr_i) begin
         lost_nxt_s     = 3'b000;
         lost_cnt_nxt_s = {LOST_CNT_W{1'b0}};
      end else if (cnt_sum_s > cnt_max_s) begin
         lost_nxt_s     = lost_r | lost_ev_s;
         lost_cnt_nxt_s = {LOST_CNT_W{1'b1}};
      end else begin
         lost_nxt_s     = lost_r | lost_ev_s;
         lost_cnt_nxt_s = cnt_sum_s[LOST_CNT_W-1:0];
      end
   end

   // Handshake FSM: next state plus next request, ID and selected source.
   always_comb begin
      state_nxt_s = state_r;
      req_nxt_s   = irq_req_r;
      id_nxt_s    = irq_id_r;
      sel_nxt_s   = sel_r;
      case (state_r)
         IDLE: begin
            if (elig_s[0]) begin
               state_nxt_s = REQ;
               req_nxt_s   = 1'b1;
               id_nxt_s    = ID_TIMER;
               sel_nxt_s   = 3'b001;
            end else if (elig_s[1]) begin
               state_nxt_s = REQ;
               req_nxt_s   = 1'b1;
               id_nxt_s    = ID_GPIO;
               sel_nxt_s   = 3'b010;
            end else if (elig_s[2]) begin
               state_nxt_s = REQ;
               req_nxt_s   = 1'b1;
               id_nxt_s    = ID_DEBUG;
               sel_nxt_s   = 3'b100;
            end else begin
               state_nxt_s = IDLE;
               req_nxt_s   = 1'b0;
            end
         end
         REQ: begin
            // The offered ID is frozen. No preemption, only ack or withdraw.
            if (ack_ok_s) begin
               state_nxt_s = DRAIN;
               req_nxt_s   = 1'b0;
            end else if (debug_mode_i || !held_elig_s) begin
               state_nxt_s = IDLE;
               req_nxt_s   = 1'b0;
            end else begin
               state_nxt_s = REQ;
               req_nxt_s   = 1'b1;
            end
         end
         DRAIN: begin
            // One idle cycle so the core sees irq_req_o low before the next request.
            state_nxt_s = IDLE;
            req_nxt_s   = 1'b0;
         end
         default: begin
            state_nxt_s = IDLE;
            req_nxt_s   = 1'b0;
            sel_nxt_s   = 3'b000;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_req_r <= 1'b0;
         irq_id_r  <= 5'd0;
         sel_r     <= 3'b000;
         ack_err_r <= 1'b0;
      end else begin
         irq_req_r <= req_nxt_s;
         irq_id_r  <= id_nxt_s;
         sel_r     <= sel_nxt_s;
         ack_err_r <= ack_err_nxt_s;
      end
   end

   // Pending bits, lost flags and lost counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r  <= 3'b000;
         lost_r     <= 3'b000;
         lost_cnt_r <= {LOST_CNT_W{1'b0}};
      end else begin
         pending_r  <= pending_nxt_s;
         lost_r     <= lost_nxt_s;
         lost_cnt_r <= lost_cnt_nxt_s;
      end
   end

   assign irq_req_o  = irq_req_r;
   assign irq_id_o   = irq_id_r;
   assign ack_err_o  = ack_err_r;
   assign pending_o  = pending_r;
   assign lost_o     = lost_r;
   assign lost_cnt_o = lost_cnt_r;

endmodule

// File: tb/tb_riscv_irq_pend_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_irq_pend_ctrl
//
// Purpose:
//    Self-checking bench for riscv_irq_pend_ctrl. It runs a table of per-cycle
//    vectors. Each vector holds the inputs for one clock and the outputs
//    expected just after that edge. Hand-written sequences then cover counter
//    saturation and an asynchronous reset in the middle of a handshake.
// -----------------------------------------------------------------------------
module tb_riscv_irq_pend_ctrl;

   logic       clk;
   logic       rst_n;
   logic       irq_timer_pulse_i;
   logic       irq_gpio_pulse_i;
   logic       irq_debug_pulse_i;
   logic [2:0] irq_en_i;
   logic       mie_i;
   logic       debug_mode_i;
   logic       irq_req_o;
   logic [4:0] irq_id_o;
   logic       irq_ack_i;
   logic [4:0] irq_id_i;
   logic [2:0] pending_o;
   logic [2:0] lost_o;
   logic [7:0] lost_cnt_o;
   logic       lost_clr_i;
   logic       ack_err_o;

   int n_cmp;
   int n_err;

   typedef struct {
      logic [2:0] pulse;   // {debug,gpio,timer}
      logic [2:0] en;
      logic       mie;
      logic       dbg;
      logic       ack;
      logic [4:0] aid;
      logic       clr;
      logic       req;
      logic [4:0] id;
      logic [2:0] pend;
      logic [2:0] lost;
      logic [7:0] cnt;
      logic       err;
   } vec_t;

   vec_t vecs[$];

   riscv_irq_pend_ctrl #(
      .ID_TIMER   (5'd7),
      .ID_GPIO    (5'd11),
      .ID_DEBUG   (5'd12),
      .LOST_CNT_W (8)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .irq_timer_pulse_i (irq_timer_pulse_i),
      .irq_gpio_pulse_i  (irq_gpio_pulse_i),
      .irq_debug_pulse_i (irq_debug_pulse_i),
      .irq_en_i          (irq_en_i),
      .mie_i             (mie_i),
      .debug_mode_i      (debug_mode_i),
      .irq_req_o         (irq_req_o),
      .irq_id_o          (irq_id_o),
      .irq_ack_i         (irq_ack_i),
      .irq_id_i          (irq_id_i),
      .pending_o         (pending_o),
      .lost_o            (lost_o),
      .lost_cnt_o        (lost_cnt_o),
      .lost_clr_i        (lost_clr_i),
      .ack_err_o         (ack_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [2:0] pulse, input logic [2:0] en,
                               input logic mie, input logic dbg, input logic ack,
                               input logic [4:0] aid, input logic clr,
                               input logic req, input logic [4:0] id,
                               input logic [2:0] pend, input logic [2:0] lost,
                               input logic [7:0] cnt, input logic err);
      vec_t v;
      v.pulse = pulse; v.en = en; v.mie = mie; v.dbg = dbg; v.ack = ack;
      v.aid = aid; v.clr = clr; v.req = req; v.id = id; v.pend = pend;
      v.lost = lost; v.cnt = cnt; v.err = err;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] pulse, input logic [2:0] en, input logic mie,
                        input logic dbg, input logic ack, input logic [4:0] aid,
                        input logic clr);
      irq_timer_pulse_i = pulse[0];
      irq_gpio_pulse_i  = pulse[1];
      irq_debug_pulse_i = pulse[2];
      irq_en_i          = en;
      mie_i             = mie;
      debug_mode_i      = dbg;
      irq_ack_i         = ack;
      irq_id_i          = aid;
      lost_clr_i        = clr;
   endtask

   // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic [2:0] pulse, input logic clr);
      drive(pulse, 3'b111, 1'b1, 1'b0, 1'b0, 5'd0, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic req, input logic [4:0] id,
                            input logic [2:0] pend, input logic [2:0] lost,
                            input logic [7:0] cnt, input logic err);
      cmp({tag, " req"},  {31'd0, irq_req_o},  {31'd0, req});
      cmp({tag, " id"},   {27'd0, irq_id_o},   {27'd0, id});
      cmp({tag, " pend"}, {29'd0, pending_o},  {29'd0, pend});
      cmp({tag, " lost"}, {29'd0, lost_o},     {29'd0, lost});
      cmp({tag, " cnt"},  {24'd0, lost_cnt_o}, {24'd0, cnt});
      cmp({tag, " err"},  {31'd0, ack_err_o},  {31'd0, err});
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;

      // Columns: pulse{d,g,t} en mie dbg ack aid clr | req id pend lost cnt err
      // Timer request, then ack.
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd0, 3'b000,3'b000,8'd0,1'b0)); // 0
      vecs.push_back(mk(3'b001,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd0, 3'b001,3'b000,8'd0,1'b0)); // 1
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd7, 3'b001,3'b000,8'd0,1'b0)); // 2
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd7, 3'b001,3'b000,8'd0,1'b0)); // 3
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b1,5'd7, 1'b0, 1'b0,5'd7, 3'b000,3'b000,8'd0,1'b0)); // 4
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd7, 3'b000,3'b000,8'd0,1'b0)); // 5
      // Timer and gpio together: 7 first, then DRAIN, then 11.
      vecs.push_back(mk(3'b011,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd7, 3'b011,3'b000,8'd0,1'b0)); // 6
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd7, 3'b011,3'b000,8'd0,1'b0)); // 7
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b1,5'd7, 1'b0, 1'b0,5'd7, 3'b010,3'b000,8'd0,1'b0)); // 8
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd7, 3'b010,3'b000,8'd0,1'b0)); // 9
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd11,3'b010,3'b000,8'd0,1'b0)); // 10
      // Wrong-ID ack while offering 11.
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b1,5'd7, 1'b0, 1'b1,5'd11,3'b010,3'b000,8'd0,1'b1)); // 11
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd11,3'b010,3'b000,8'd0,1'b0)); // 12
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b1,5'd11,1'b0, 1'b0,5'd11,3'b000,3'b000,8'd0,1'b0)); // 13
      // Three gpio pulses: two are lost. Then clear with a same-cycle fourth pulse.
      vecs.push_back(mk(3'b010,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd11,3'b010,3'b000,8'd0,1'b0)); // 14
      vecs.push_back(mk(3'b010,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd11,3'b010,3'b010,8'd1,1'b0)); // 15
      vecs.push_back(mk(3'b010,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd11,3'b010,3'b010,8'd2,1'b0)); // 16
      vecs.push_back(mk(3'b010,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b1, 1'b1,5'd11,3'b010,3'b000,8'd0,1'b0)); // 17
      // Gpio pulse plus matching ack: the bit stays set and nothing is lost.
      vecs.push_back(mk(3'b010,3'b111,1'b1,1'b0,1'b1,5'd11,1'b0, 1'b0,5'd11,3'b010,3'b000,8'd0,1'b0)); // 18
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd11,3'b010,3'b000,8'd0,1'b0)); // 19
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd11,3'b010,3'b000,8'd0,1'b0)); // 20
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b1,5'd11,1'b0, 1'b0,5'd11,3'b000,3'b000,8'd0,1'b0)); // 21
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd11,3'b000,3'b000,8'd0,1'b0)); // 22
      // Debug mode withdraws timer request 7, and it is re-issued afterwards.
      vecs.push_back(mk(3'b001,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd11,3'b001,3'b000,8'd0,1'b0)); // 23
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd7, 3'b001,3'b000,8'd0,1'b0)); // 24
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b1,1'b0,5'd0, 1'b0, 1'b0,5'd7, 3'b001,3'b000,8'd0,1'b0)); // 25
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b1,1'b0,5'd0, 1'b0, 1'b0,5'd7, 3'b001,3'b000,8'd0,1'b0)); // 26
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd7, 3'b001,3'b000,8'd0,1'b0)); // 27
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b1,5'd7, 1'b0, 1'b0,5'd7, 3'b000,3'b000,8'd0,1'b0)); // 28
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd7, 3'b000,3'b000,8'd0,1'b0)); // 29
      // Debug source with mie=0, including a pulse plus matching ack.
      vecs.push_back(mk(3'b100,3'b111,1'b0,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd7, 3'b100,3'b000,8'd0,1'b0)); // 30
      vecs.push_back(mk(3'b000,3'b111,1'b0,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd12,3'b100,3'b000,8'd0,1'b0)); // 31
      vecs.push_back(mk(3'b100,3'b111,1'b0,1'b0,1'b1,5'd12,1'b0, 1'b0,5'd12,3'b100,3'b000,8'd0,1'b0)); // 32
      vecs.push_back(mk(3'b000,3'b111,1'b0,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd12,3'b100,3'b000,8'd0,1'b0)); // 33
      vecs.push_back(mk(3'b000,3'b111,1'b0,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd12,3'b100,3'b000,8'd0,1'b0)); // 34
      // Timer arriving while 12 is on offer: no preemption.
      vecs.push_back(mk(3'b001,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd12,3'b101,3'b000,8'd0,1'b0)); // 35
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b1,5'd12,1'b0, 1'b0,5'd12,3'b001,3'b000,8'd0,1'b0)); // 36
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd12,3'b001,3'b000,8'd0,1'b0)); // 37
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd7, 3'b001,3'b000,8'd0,1'b0)); // 38
      // Dropping the enable withdraws; an ack in IDLE is an error.
      vecs.push_back(mk(3'b000,3'b110,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd7, 3'b001,3'b000,8'd0,1'b0)); // 39
      vecs.push_back(mk(3'b000,3'b110,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd7, 3'b001,3'b000,8'd0,1'b0)); // 40
      vecs.push_back(mk(3'b000,3'b110,1'b1,1'b0,1'b1,5'd7, 1'b0, 1'b0,5'd7, 3'b001,3'b000,8'd0,1'b1)); // 41
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd7, 3'b001,3'b000,8'd0,1'b0)); // 42
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b1,5'd7, 1'b0, 1'b0,5'd7, 3'b000,3'b000,8'd0,1'b0)); // 43
      // Ack in DRAIN is also an error.
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b1,5'd7, 1'b0, 1'b0,5'd7, 3'b000,3'b000,8'd0,1'b1)); // 44
      // Three simultaneous lost events add 3.
      vecs.push_back(mk(3'b111,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd7, 3'b111,3'b000,8'd0,1'b0)); // 45
      vecs.push_back(mk(3'b111,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd7, 3'b111,3'b111,8'd3,1'b0)); // 46
      vecs.push_back(mk(3'b001,3'b111,1'b1,1'b0,1'b1,5'd7, 1'b0, 1'b0,5'd7, 3'b111,3'b111,8'd3,1'b0)); // 47
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b0,5'd7, 3'b111,3'b111,8'd3,1'b0)); // 48
      vecs.push_back(mk(3'b000,3'b111,1'b1,1'b0,1'b0,5'd0, 1'b0, 1'b1,5'd7, 3'b111,3'b111,8'd3,1'b0)); // 49

      // Reset and the reset-state check.
      rst_n = 1'b0;
      drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_all("reset", 1'b0, 5'd0, 3'b000, 3'b000, 8'd0, 1'b0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].pulse, vecs[i].en, vecs[i].mie, vecs[i].dbg,
               vecs[i].ack, vecs[i].aid, vecs[i].clr);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].id, vecs[i].pend,
                   vecs[i].lost, vecs[i].cnt, vecs[i].err);
      end

      // Saturation: request 7 stays on offer, and gpio pulses pile up lost events.
      for (int k = 0; k < 251; k++) begin
         step(3'b010, 1'b0);
      end
      check_all("sat254", 1'b1, 5'd7, 3'b111, 3'b111, 8'd254, 1'b0);
      step(3'b010, 1'b0);
      check_all("sat255", 1'b1, 5'd7, 3'b111, 3'b111, 8'd255, 1'b0);
      step(3'b111, 1'b0);
      check_all("sat_hold", 1'b1, 5'd7, 3'b111, 3'b111, 8'd255, 1'b0);
      step(3'b000, 1'b1);
      check_all("clr", 1'b1, 5'd7, 3'b111, 3'b000, 8'd0, 1'b0);

      // Asynchronous reset in the middle of the handshake.
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", 1'b0, 5'd0, 3'b000, 3'b000, 8'd0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      step(3'b000, 1'b0);
      check_all("post_rst", 1'b0, 5'd0, 3'b000, 3'b000, 8'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/riscv_irq_pend_ctrl.md
Name: riscv_irq_pend_ctrl

Overview:
- Sits between the interrupt synchronizer and the core's interrupt interface.
- Latches the single-cycle synchronized event pulses (timer, gpio, debug) into per-source pending bits and applies the CSR enables.
- Arbitrates by fixed priority and drives a stable request/ID handshake to the core.
- Reports lost events (a new pulse on an already-pending source) and acknowledges that carry a mismatched ID.

Parameters:
- ID_TIMER, 5'd7, exception code issued for the timer source.
- ID_GPIO, 5'd11, exception code issued for the gpio (machine external) source.
- ID_DEBUG, 5'd12, exception code issued for the debug source.
- LOST_CNT_W, 8, width of the saturating lost-event counter.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- irq_timer_pulse_i  input  1  synchronized rising-edge pulse, timer
- irq_gpio_pulse_i  input  1  synchronized rising-edge pulse, gpio
- irq_debug_pulse_i  input  1  synchronized rising-edge pulse, debug
- irq_en_i  input  3  per-source enable {debug,gpio,timer} (mie bits)
- mie_i  input  1  global interrupt enable (mstatus.MIE); does not gate debug
- debug_mode_i  input  1  core is in debug mode
- irq_req_o  output  1  interrupt request to core
- irq_id_o  output  5  ID of the requested interrupt, valid while irq_req_o=1
- irq_ack_i  input  1  core acknowledge, single-cycle pulse
- irq_id_i  input  5  ID being acknowledged
- pending_o  output  3  pending bits {debug,gpio,timer}
- lost_o  output  3  sticky lost flags {debug,gpio,timer}
- lost_cnt_o  output  LOST_CNT_W  saturating count of lost events
- lost_clr_i  input  1  clears lost_o and lost_cnt_o
- ack_err_o  output  1  one-cycle pulse on ack with a mismatched ID or no request

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: every register and output is 0. irq_req_o=0, irq_id_o=0, pending=0, lost=0, lost_cnt=0, ack_err_o=0. FSM resets to IDLE.
- Asserting rst_n mid-handshake drops irq_req_o immediately; the pending event is discarded.
- Pending bit set: a pulse on cycle N gives pending=1 at N+1, regardless of enables.
- Pending bit clear: only by a valid ack of that source's ID.
- Pulse and valid ack for the same source in the same cycle: the pending bit stays 1 (the new event wins) and no lost event is recorded.
- Lost event: a pulse while the pending bit is already 1 and no clearing ack arrives that cycle.
  - Sets the lost bit (sticky).
  - Increments lost_cnt, saturating at all-ones. Simultaneous lost events on k sources add k.
  - lost_clr_i has priority over a same-cycle increment (result is 0).
- Eligibility:
  - timer: pending & irq_en_i[0] & mie_i & ~debug_mode_i
  - gpio: pending & irq_en_i[1] & mie_i & ~debug_mode_i
  - debug: pending & irq_en_i[2] & ~debug_mode_i
- Priority: timer > gpio > debug.
- FSM states: IDLE, REQ, DRAIN.
  - IDLE: if any source is eligible, register the winner's ID into irq_id_o and set irq_req_o=1 on the next edge, then go to REQ. Latency from pulse to irq_req_o is 2 cycles (N+2).
  - REQ: irq_req_o and irq_id_o are held constant; there is no preemption by higher-priority arrivals. Transitions:
    - irq_ack_i with irq_id_i==irq_id_o: clear that pending bit, irq_req_o=0 next cycle, go to DRAIN.
    - irq_ack_i with any other ID: ack_err_o pulses for 1 cycle, nothing is cleared, stay in REQ.
    - debug_mode_i=1 or the held source becomes ineligible (enable or mie_i dropped) without an ack: withdraw, irq_req_o=0 next cycle, pending is kept, go to IDLE.
  - DRAIN: one cycle with irq_req_o=0 so the core samples the deassertion, then go to IDLE. Back-to-back requests are therefore spaced at least 2 cycles apart.
- irq_ack_i received in IDLE or DRAIN: ack_err_o pulses and no state changes.
- irq_id_o keeps its last value when irq_req_o=0.
- pending_o and lost_o are direct register outputs.

Test Plan:
- Reset then timer pulse at cycle 10 with irq_en_i=3'b111, mie_i=1 -> pending_o=3'b001 at 11; irq_req_o=1, irq_id_o=7 at 12; ack id 7 at 14 -> irq_req_o=0 at 15, pending_o=0.
- gpio and timer pulse in the same cycle -> first request ID 7; after ack, DRAIN cycle, then ID 11 with irq_req_o re-asserted exactly 2 cycles after the first deassertion.
- gpio pulses 3 times while pending and unacked -> lost_o=3'b010, lost_cnt_o=2. lost_clr_i with a same-cycle 4th pulse -> lost_cnt_o=0.
- While REQ with ID 11, ack with irq_id_i=7 -> ack_err_o=1 for one cycle, irq_req_o stays 1, pending_o unchanged.
- While REQ with ID 7, raise debug_mode_i -> irq_req_o=0 next cycle, pending_o[0]=1. Drop debug_mode_i -> request ID 7 re-issued 1 cycle later.
- debug pulse with mie_i=0, irq_en_i[2]=1 -> request ID 12. Pulse and matching ack in the same cycle -> pending stays 1, lost_cnt_o unchanged.
